// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB sizing, lane entry types and round-robin helper.
//   NUM_ALU/NUM_MULT : FU mix; FUs 0..NUM_ALU-1 are ALUs, the rest multipliers
//   NUM_FU, NUM_CDB  : requesters and broadcast lanes (1 <= NUM_CDB <= NUM_FU)
//   Per-FU packed vectors place FU i in slice [i*W +: W] (ALUs first, then multipliers).
package cdb_arbiter_pkg;
    localparam int NUM_ALU  = 3;
    localparam int NUM_MULT = 2;
    localparam int NUM_FU   = NUM_ALU + NUM_MULT;
    localparam int NUM_CDB  = 2;
    localparam int T_IDX_W  = 6;
    localparam int DATA_W   = 64;
    localparam int SRC_W    = $clog2(NUM_FU);

    typedef logic [SRC_W-1:0] src_t;

    typedef struct packed {
        logic               valid;
        logic [T_IDX_W-1:0] T_idx;
        logic [DATA_W-1:0]  result;
        src_t               src;
    } CDB_ENTRY_t;

    typedef CDB_ENTRY_t CDB_PACKET_t [NUM_CDB];

    // NUM_FU need not be a power of two, so wrap by compare rather than truncation.
    function automatic src_t next_idx(input src_t i);
        return (i == src_t'(NUM_FU - 1)) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU-bank / CDB bundle around the arbiter.
//   fu_done, fu_T_idx, fu_result, rollback : FU bank and flush toward the arbiter
//   full_hazard                            : per-FU hold request back to the FU bank
//   cdb_valid, cdb_T_idx, cdb_result, cdb_src : registered broadcast lanes
//   master = FU bank / complete-stage side, slave = arbiter side.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;
    logic [NUM_FU-1:0]         fu_done;
    logic [NUM_FU*T_IDX_W-1:0] fu_T_idx;
    logic [NUM_FU*DATA_W-1:0]  fu_result;
    logic                      rollback;
    logic [NUM_FU-1:0]         full_hazard;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*T_IDX_W-1:0] cdb_T_idx;
    logic [NUM_CDB*DATA_W-1:0] cdb_result;
    logic [NUM_CDB*SRC_W-1:0]  cdb_src;

    modport master (
        output fu_done, fu_T_idx, fu_result, rollback,
        input  full_hazard, cdb_valid, cdb_T_idx, cdb_result, cdb_src
    );
    modport slave (
        input  fu_done, fu_T_idx, fu_result, rollback,
        output full_hazard, cdb_valid, cdb_T_idx, cdb_result, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter_rr_multi_select.sv
// cdb_arbiter_rr_multi_select: combinational rotating pick of up to NUM_CDB requesters.
//   req        : request vector, bit 0 = FU 0
//   ptr        : highest-priority index for this scan
//   grant      : one-hot-per-winner grant vector
//   lane_idx   : index granted onto lane k (k-th winner in scan order)
//   lane_valid : lane k received a winner
//   last_idx   : last winner in scan order (valid when any_grant)
//   any_grant  : at least one winner
module cdb_arbiter_rr_multi_select
    import cdb_arbiter_pkg::*;
(
    input  logic [NUM_FU-1:0]            req,
    input  src_t                         ptr,
    output logic [NUM_FU-1:0]            grant,
    output logic [NUM_CDB-1:0][SRC_W-1:0] lane_idx,
    output logic [NUM_CDB-1:0]           lane_valid,
    output src_t                         last_idx,
    output logic                         any_grant
);
    src_t idx;
    int   cnt;

    always_comb begin
        grant      = '0;
        lane_idx   = '0;
        lane_valid = '0;
        last_idx   = ptr;
        idx        = ptr;
        cnt        = 0;
        for (int n = 0; n < NUM_FU; n++) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (req[idx] && cnt == k) begin
                    lane_idx[k]   = idx;
                    lane_valid[k] = 1'b1;
                end
            end
            if (req[idx] && cnt < NUM_CDB) begin
                grant[idx] = 1'b1;
                last_idx   = idx;
                cnt        = cnt + 1;
            end
            idx = next_idx(idx);
        end
        any_grant = |grant;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares NUM_CDB broadcast lanes among the FU bank in rotating priority.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : cdb_arbiter_if.slave (FU requests in, full_hazard and CDB lanes out)
// Winners are registered onto the lanes (one cycle latency); losers get full_hazard
// and must hold their result. Rollback suppresses grants and hazards for the cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    src_t                          rr_ptr;
    logic [NUM_FU-1:0]             req;
    logic [NUM_FU-1:0]             grant;
    logic [NUM_CDB-1:0][SRC_W-1:0] lane_idx;
    logic [NUM_CDB-1:0]            lane_valid;
    src_t                          last_idx;
    logic                          any_grant;
    logic [T_IDX_W-1:0]            fu_tag [NUM_FU];
    logic [DATA_W-1:0]             fu_val [NUM_FU];
    CDB_PACKET_t                   lanes;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_tag[i] = bus.fu_T_idx[i*T_IDX_W +: T_IDX_W];
        assign fu_val[i] = bus.fu_result[i*DATA_W +: DATA_W];
    end

    // Masking requests during rollback zeroes every grant, so no lane loads.
    assign req = bus.fu_done & {NUM_FU{~bus.rollback}};

    cdb_arbiter_rr_multi_select u_sel (
        .req        (req),
        .ptr        (rr_ptr),
        .grant      (grant),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .last_idx   (last_idx),
        .any_grant  (any_grant)
    );

    // Rollback must clear hazards explicitly: with grants masked, fu_done & ~grant alone would stall everyone.
    assign bus.full_hazard = reset ? (bus.fu_done & ~grant & {NUM_FU{~bus.rollback}}) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            for (int k = 0; k < NUM_CDB; k++) lanes[k] <= '0;
        end else begin
            if (any_grant) rr_ptr <= next_idx(last_idx);
            for (int k = 0; k < NUM_CDB; k++) begin
                lanes[k].valid <= lane_valid[k];
                if (lane_valid[k]) begin
                    lanes[k].T_idx  <= fu_tag[lane_idx[k]];
                    lanes[k].result <= fu_val[lane_idx[k]];
                    lanes[k].src    <= lane_idx[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        assign bus.cdb_valid[k]                      = lanes[k].valid;
        assign bus.cdb_T_idx[k*T_IDX_W +: T_IDX_W]   = lanes[k].T_idx;
        assign bus.cdb_result[k*DATA_W +: DATA_W]    = lanes[k].result;
        assign bus.cdb_src[k*SRC_W +: SRC_W]         = lanes[k].src;
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.
//   Drives the FU side of cdb_arbiter_if on falling edges and checks lanes,
//   full_hazard and the rotating pointer against hand-computed values.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_fu(input int i, input logic [T_IDX_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.fu_T_idx[i*T_IDX_W +: T_IDX_W] = t;
        bus.fu_result[i*DATA_W +: DATA_W]  = d;
    endtask

    initial begin
        bus.fu_done  = 5'b11111;
        bus.rollback = 1'b0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, T_IDX_W'(i + 8), DATA_W'(64'h100 + i));
        #12;
        check("rst_hazard", bus.full_hazard, 5'b00000);
        check("rst_valid", bus.cdb_valid, 2'b00);
        check("rst_src", bus.cdb_src, 6'h00);
        check("rst_ptr", dut.rr_ptr, 3'd0);
        bus.fu_done = 5'b00000;
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        check("idle_valid", bus.cdb_valid, 2'b00);
        check("idle_ptr", dut.rr_ptr, 3'd0);

        // Two requesters from rr_ptr=0
        set_fu(1, 6'd3, 64'hAAAA);
        set_fu(2, 6'd7, 64'hBBBB);
        bus.fu_done = 5'b00110;
        #1 check("two_hazard", bus.full_hazard, 5'b00000);
        @(negedge clock);
        check("two_valid", bus.cdb_valid, 2'b11);
        check("two_tag", bus.cdb_T_idx, 12'h1C3);
        check("two_src", bus.cdb_src, 6'h11);
        check("two_res0", bus.cdb_result[63:0], 64'hAAAA);
        check("two_res1", bus.cdb_result[127:64], 64'hBBBB);
        check("two_ptr", dut.rr_ptr, 3'd3);
        bus.fu_done = 5'b00000;
        @(negedge clock);
        check("zero_valid", bus.cdb_valid, 2'b00);
        check("zero_ptr", dut.rr_ptr, 3'd3);

        // Single requester: only lane 0 fills, pointer wraps 4 -> 0
        bus.fu_done = 5'b10000;
        @(negedge clock);
        check("one_valid", bus.cdb_valid, 2'b01);
        check("one_src0", bus.cdb_src[2:0], 3'd4);
        check("one_tag0", bus.cdb_T_idx[5:0], 6'd12);
        check("one_ptr", dut.rr_ptr, 3'd0);

        // Oversubscription, all five held
        bus.fu_done = 5'b11111;
        #1 check("ov1_hazard", bus.full_hazard, 5'b11100);
        @(negedge clock);
        check("ov1_src", bus.cdb_src, 6'h08);
        check("ov1_valid", bus.cdb_valid, 2'b11);
        check("ov1_ptr", dut.rr_ptr, 3'd2);
        #1 check("ov2_hazard", bus.full_hazard, 5'b10011);
        @(negedge clock);
        check("ov2_src", bus.cdb_src, 6'h1A);
        check("ov2_ptr", dut.rr_ptr, 3'd4);
        #1 check("ov3_hazard", bus.full_hazard, 5'b01110);
        @(negedge clock);
        check("ov3_src", bus.cdb_src, 6'h04);
        check("ov3_ptr", dut.rr_ptr, 3'd1);
        #1 check("ov4_hazard", bus.full_hazard, 5'b11001);
        @(negedge clock);
        check("ov4_src", bus.cdb_src, 6'h11);
        check("ov4_ptr", dut.rr_ptr, 3'd3);

        // Explicit wrap from rr_ptr=4
        bus.fu_done = 5'b01000;
        @(negedge clock);
        check("pre_wrap_ptr", dut.rr_ptr, 3'd4);
        bus.fu_done = 5'b10001;
        #1 check("wrap_hazard", bus.full_hazard, 5'b00000);
        @(negedge clock);
        check("wrap_valid", bus.cdb_valid, 2'b11);
        check("wrap_src", bus.cdb_src, 6'h04);
        check("wrap_ptr", dut.rr_ptr, 3'd1);

        // Rollback: in-flight lanes still visible, nothing new granted
        bus.fu_done  = 5'b01010;
        bus.rollback = 1'b1;
        #1 check("rb_hazard", bus.full_hazard, 5'b00000);
        check("rb_inflight", bus.cdb_valid, 2'b11);
        @(negedge clock);
        check("rb_valid", bus.cdb_valid, 2'b00);
        check("rb_ptr", dut.rr_ptr, 3'd1);
        bus.rollback = 1'b0;

        // Asynchronous reset mid-stream
        bus.fu_done = 5'b11111;
        @(negedge clock);
        check("ar_pre_valid", bus.cdb_valid, 2'b11);
        check("ar_pre_ptr", dut.rr_ptr, 3'd3);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", bus.cdb_valid, 2'b00);
        check("ar_src", bus.cdb_src, 6'h00);
        check("ar_ptr", dut.rr_ptr, 3'd0);
        check("ar_hazard", bus.full_hazard, 5'b00000);
        @(negedge clock);
        reset = 1'b1;
        bus.fu_done = 5'b10010;
        #1 check("post_hazard", bus.full_hazard, 5'b00000);
        @(negedge clock);
        check("post_valid", bus.cdb_valid, 2'b11);
        check("post_src", bus.cdb_src, 6'h21);
        check("post_ptr", dut.rr_ptr, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
